vga_capture: RTL and testbench

Video-input receiver for the Game-of-life display path. It is the sink end of the link that the VGA timing generator drives. It accepts hsync/vsync/data_enable plus 24-bit RGB, recovers pixel coordinates, thresholds each pixel to alive/dead, and writes 2×2-pixel cells into the cell memory through a single write port. A lock FSM gates writes so that only frames with correct geometry reach memory.

---
 rtl/vga_capture_if.sv | 29 ++
 rtl/vga_capture.sv | 181 ++++++++++++++++++
 tb/tb_vga_capture.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// Video-input / cell-write bundle between the VGA timing source, vga_capture and the cell memory.
// cell_we is a one-cycle valid for cell_addr/cell_live; the memory never back-pressures (always ready).
interface vga_capture_if #(
  parameter int WIDTH = 11
);
  logic               hsync;
  logic               vsync;
  logic               data_enable;
  logic [7:0]         video_red;
  logic [7:0]         video_green;
  logic [7:0]         video_blue;
  logic [2*WIDTH-1:0] cell_addr;
  logic               cell_live;
  logic               cell_we;
  logic               locked;
  logic               frame_done;
  logic [7:0]         err_count;
  logic [1:0]         dbg_state;

  modport master (
    output hsync, vsync, data_enable, video_red, video_green, video_blue,
    input  cell_addr, cell_live, cell_we, locked, frame_done, err_count, dbg_state
  );

  modport slave (
    input  hsync, vsync, data_enable, video_red, video_green, video_blue,
    output cell_addr, cell_live, cell_we, locked, frame_done, err_count, dbg_state
  );
endinterface

// File: rtl/vga_capture.sv
// Video receiver: recovers x/y, thresholds pixels and writes 2x2 cells once geometry is locked.
// Optional CAPTURE_HPAIR_EN: cell is alive if either pixel of the even-line pair is alive.
module vga_capture #(
  parameter int WIDTH     = 11,
  parameter int HSIZE     = 0,
  parameter int VSIZE     = 0,
  parameter int HSPP      = 0,
  parameter int VSPP      = 0,
  parameter int P_PARAM_N = 0,
  parameter int P_PARAM_M = 0,
  parameter int THRESH    = 384
) (
  input logic           clk,
  input logic           rst,
  vga_capture_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEASURE = 2'd1, S_LOCKED = 2'd2} state_t;

  localparam logic [WIDTH-1:0]   L_HSIZE  = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0]   L_VSIZE  = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0]   L_VLAST  = WIDTH'(VSIZE - 1);
  localparam logic [WIDTH-1:0]   L_MAX    = '1;
  localparam logic [WIDTH-2:0]   L_M      = (WIDTH-1)'(P_PARAM_M);
  localparam logic [2*WIDTH-1:0] L_N      = (2*WIDTH)'(P_PARAM_N);
  localparam logic [9:0]         L_THRESH = 10'(THRESH);

  state_t             r_state;
  logic               r_armed, r_bad, r_locked, r_frame_done;
  logic [7:0]         r_err;
  logic               r_hs, r_vs, r_de, r_de_d, r_vs_act_d;
  logic [7:0]         r_red, r_green, r_blue;
  logic [WIDTH-1:0]   r_x, r_y;
  logic               r2_we, r2_alive;
  logic [WIDTH-2:0]   r2_xc, r2_yc;
  logic               r_cell_we, r_cell_live;
  logic [2*WIDTH-1:0] r_cell_addr;

  logic               w_vs_act, w_hs_act, w_vs_edge, w_de_fall;
  logic               w_line_bad, w_frame_ok, w_alive, w_alive_cell, w_pick;
  logic [WIDTH-1:0]   w_lines;
  logic [9:0]         w_sum;
  logic [7:0]         w_err_inc;
  logic [2*WIDTH-1:0] w_addr;

  assign w_vs_act   = (VSPP != 0) ? r_vs : ~r_vs;
  assign w_hs_act   = (HSPP != 0) ? r_hs : ~r_hs;
  assign w_vs_edge  = w_vs_act & ~r_vs_act_d;
  assign w_de_fall  = r_de_d & ~r_de;
  assign w_line_bad = w_de_fall && (r_x != L_HSIZE);
  // A line ending on the same cycle as the vsync edge counts towards the closing frame.
  assign w_lines    = (w_de_fall && r_y != L_MAX) ? r_y + 1'b1 : r_y;
  assign w_frame_ok = (w_lines == L_VSIZE);
  assign w_err_inc  = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_sum      = {2'b0, r_red} + {2'b0, r_green} + {2'b0, r_blue};
  assign w_alive    = (w_sum >= L_THRESH);
  assign w_addr     = {{(WIDTH+1){1'b0}}, r2_yc} * L_N + {{(WIDTH+1){1'b0}}, r2_xc};

`ifdef CAPTURE_HPAIR_EN
  logic r_even_alive;
  assign w_pick       = r_x[0];
  assign w_alive_cell = w_alive | r_even_alive;
`else
  assign w_pick       = ~r_x[0];
  assign w_alive_cell = w_alive;
`endif

  // Input stage, coordinate counters and the two-stage write pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs        <= (HSPP == 0);
      r_vs        <= (VSPP == 0);
      r_de        <= 1'b0;
      r_de_d      <= 1'b0;
      r_vs_act_d  <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r2_we       <= 1'b0;
      r2_alive    <= 1'b0;
      r2_xc       <= '0;
      r2_yc       <= '0;
      r_cell_we   <= 1'b0;
      r_cell_live <= 1'b0;
      r_cell_addr <= '0;
`ifdef CAPTURE_HPAIR_EN
      r_even_alive <= 1'b0;
`endif
    end else begin
      r_hs       <= bus.hsync;
      r_vs       <= bus.vsync;
      r_de       <= bus.data_enable;
      r_red      <= bus.video_red;
      r_green    <= bus.video_green;
      r_blue     <= bus.video_blue;
      r_de_d     <= r_de;
      r_vs_act_d <= w_vs_act;

      if (r_de) begin
        if (r_x != L_MAX) r_x <= r_x + 1'b1;
      end else if (w_de_fall || w_hs_act) begin
        r_x <= '0;
      end
      r_y <= w_vs_edge ? '0 : w_lines;

`ifdef CAPTURE_HPAIR_EN
      if (r_de && !r_x[0]) r_even_alive <= w_alive;
`endif
      r2_we    <= r_de && (r_state == S_LOCKED) && !r_y[0] && w_pick &&
                  (r_x < L_HSIZE) && (r_y[WIDTH-1:1] < L_M);
      r2_alive <= w_alive_cell;
      r2_xc    <= r_x[WIDTH-1:1];
      r2_yc    <= r_y[WIDTH-1:1];

      r_cell_we   <= r2_we;
      r_cell_live <= r2_we & r2_alive;
      if (r2_we) r_cell_addr <= w_addr;
    end
  end

  // Lock FSM: r_armed marks that the current frame started at a vsync edge seen in MEASURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_bad        <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vs_edge) begin
            r_state <= S_MEASURE;
            r_armed <= 1'b1;
            r_bad   <= 1'b0;
          end
        end
        S_MEASURE: begin
          if (w_vs_edge) begin
            if (r_armed && !r_bad && !w_line_bad && w_frame_ok) begin
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
            end else if (r_armed) begin
              r_err <= w_err_inc;
            end
            r_armed <= 1'b1;
            r_bad   <= 1'b0;
          end else if (w_line_bad) begin
            r_bad <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_line_bad || (w_vs_edge && !w_frame_ok)) begin
            r_state  <= S_MEASURE;
            r_locked <= 1'b0;
            r_err    <= w_err_inc;
            r_armed  <= w_vs_edge;
            r_bad    <= 1'b0;
          end else if (w_de_fall && r_y == L_VLAST) begin
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cell_addr  = r_cell_addr;
  assign bus.cell_live  = r_cell_live;
  assign bus.cell_we    = r_cell_we;
  assign bus.locked     = r_locked;
  assign bus.frame_done = r_frame_done;
  assign bus.err_count  = r_err;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: frame-level model with per-cycle compare plus literal checks.
module tb_vga_capture;
  localparam int WIDTH = 11;
  localparam int HSIZE = 8;
  localparam int VSIZE = 4;
  localparam int NC    = 4;
  localparam int MC    = 2;
  localparam int AW    = 2 * WIDTH;
  localparam int EW    = 16 + AW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  vga_capture_if #(.WIDTH(WIDTH)) bus ();
  vga_capture #(
    .WIDTH(WIDTH), .HSIZE(HSIZE), .VSIZE(VSIZE), .HSPP(0), .VSPP(0),
    .P_PARAM_N(NC), .P_PARAM_M(MC), .THRESH(384)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard: writes {cycle, addr, live}; lock/err events; frame_done cycles
  typedef struct {int cyc; bit locked; int err;} ev_t;
  logic [EW-1:0] exp_q[$];
  ev_t           ev_q[$];
  int            fd_q[$];
  int            obs_addr[$];
  int            obs_live[$];
  int            fd_seen;
  bit            e_locked;
  int            e_err;

  // frame-level model: 0 idle, 1 measuring a whole frame, 2 locked, 3 waiting for frame start
  int m_mode, m_y, m_err;
  bit m_bad, m_locked, m_prev_alive;

  function automatic bit px_alive(int r, int g, int b);
    return (r + g + b) >= 384;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic push_ev(int k);
    ev_t e;
    e.cyc = k + 2; e.locked = m_locked; e.err = m_err;
    ev_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete(); ev_q.delete(); fd_q.delete();
    m_mode = 0; m_y = 0; m_err = 0; m_bad = 0; m_locked = 0; m_prev_alive = 0;
    e_locked = 0; e_err = 0;
  endtask

  task automatic model_pixel(int k, int x, int r, int g, int b);
    bit a;
    a = px_alive(r, g, b);
    if (m_mode == 2 && m_y % 2 == 0 && x < HSIZE && m_y < VSIZE) begin
`ifdef CAPTURE_HPAIR_EN
      if (x % 2 == 1) exp_q.push_back({16'(k + 3), AW'((m_y / 2) * NC + x / 2), a | m_prev_alive});
`else
      if (x % 2 == 0) exp_q.push_back({16'(k + 3), AW'((m_y / 2) * NC + x / 2), a});
`endif
    end
    m_prev_alive = a;
  endtask

  task automatic model_line_end(int k, int len);
    if (m_mode == 2) begin
      if (len != HSIZE) begin
        m_err = sat_inc(m_err); m_locked = 0; m_mode = 3; push_ev(k);
      end else if (m_y == VSIZE - 1) begin
        fd_q.push_back(k + 2);
      end
    end else if (m_mode == 1 && len != HSIZE) begin
      m_bad = 1;
    end
    m_y++;
  endtask

  task automatic model_vsync(int k);
    case (m_mode)
      1: begin
        if (!m_bad && m_y == VSIZE) begin m_mode = 2; m_locked = 1; end
        else m_err = sat_inc(m_err);
        push_ev(k);
      end
      2: if (m_y != VSIZE) begin
        m_err = sat_inc(m_err); m_locked = 0; m_mode = 1; push_ev(k);
      end
      default: m_mode = 1;
    endcase
    m_bad = 0; m_y = 0;
  endtask

  // compare process
  always @(negedge clk) begin
    logic [EW-1:0] w;
    if (chk_en && !rst) begin
      while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        e_locked = ev_q[0].locked; e_err = ev_q[0].err;
        void'(ev_q.pop_front());
      end
      chk("locked", bus.locked, e_locked);
      chk("err_count", bus.err_count, e_err);
      if (fd_q.size() > 0 && fd_q[0] == cyc) begin
        chk("frame_done", bus.frame_done, 1);
        void'(fd_q.pop_front());
      end else begin
        chk("frame_done", bus.frame_done, 0);
      end
      if (bus.frame_done) fd_seen++;
      w = (exp_q.size() > 0) ? exp_q[0] : '0;
      if (exp_q.size() > 0 && w[EW-1 -: 16] == 16'(cyc)) begin
        void'(exp_q.pop_front());
        chk("cell_we", bus.cell_we, 1);
        chk("cell_addr", bus.cell_addr, w[AW:1]);
        chk("cell_live", bus.cell_live, w[0]);
      end else begin
        chk("cell_we", bus.cell_we, 0);
      end
      if (bus.cell_we) begin
        obs_addr.push_back(int'(bus.cell_addr));
        obs_live.push_back(int'(bus.cell_live));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_addr"}, bus.cell_addr, 0);
    chk({tag, "_live"}, bus.cell_live, 0);
    chk({tag, "_we"}, bus.cell_we, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_err"}, bus.err_count, 0);
  endtask

  task automatic pix_color(int pat, int x, output int r, output int g, output int b);
    case (pat)
      1: begin r = 128; g = 128; b = ((x / 2) % 2 == 0) ? 128 : 127; end
      2: begin r = (x % 2 == 1) ? 255 : 0; g = r; b = r; end
      default: begin r = 255; g = 255; b = 255; end
    endcase
  endtask

  task automatic vsync_pulse();
    tick(); bus.vsync = 1'b0; model_vsync(cyc);
    tick(); tick(); bus.vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_line(int len, int pat, int rst_at);
    int r, g, b;
    for (int x = 0; x < len; x++) begin
      tick();
      pix_color(pat, x, r, g, b);
      bus.data_enable = 1'b1;
      bus.video_red = 8'(r); bus.video_green = 8'(g); bus.video_blue = 8'(b);
      model_pixel(cyc, x, r, g, b);
      if (x == rst_at) begin
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        fork
          begin @(posedge clk); #3 rst = 1'b0; end
        join_none
      end
    end
    tick();
    bus.data_enable = 1'b0;
    bus.video_red = 8'd0; bus.video_green = 8'd0; bus.video_blue = 8'd0;
    model_line_end(cyc, len);
    tick(); bus.hsync = 1'b0;
    tick(); bus.hsync = 1'b1;
    tick();
  endtask

  task automatic send_frame(int pat, int bad_line, int bad_len, int rst_line, int rst_px);
    obs_addr.delete(); obs_live.delete(); fd_seen = 0;
    for (int y = 0; y < VSIZE; y++)
      send_line((y == bad_line) ? bad_len : HSIZE, pat, (y == rst_line) ? rst_px : -1);
  endtask

  task automatic check_writes(string tag, int pat);
    chk({tag, "_count"}, obs_addr.size(), 8);
    if (obs_addr.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk({tag, "_addr"}, obs_addr[i], i);
        if (pat == 0) chk({tag, "_live"}, obs_live[i], 1);
        if (pat == 1) chk({tag, "_live"}, obs_live[i], (i % 2 == 0) ? 1 : 0);
`ifdef CAPTURE_HPAIR_EN
        if (pat == 2) chk({tag, "_live"}, obs_live[i], 1);
`else
        if (pat == 2) chk({tag, "_live"}, obs_live[i], 0);
`endif
      end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bus.hsync = 1'b1; bus.vsync = 1'b1; bus.data_enable = 1'b0;
    bus.video_red = 8'd0; bus.video_green = 8'd0; bus.video_blue = 8'd0;
    model_reset();
    repeat (3) tick();
    check_all_zero("reset");
    chk("reset_state", bus.dbg_state, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // lock acquisition
    vsync_pulse();
    send_frame(0, -1, 0, -1, -1);
    chk("frame1_locked", bus.locked, 0);
    chk("frame1_writes", obs_addr.size(), 0);
    vsync_pulse();
    chk("lock_after_vsync", bus.locked, 1);

    // write pattern, threshold boundary, odd-only pixels
    send_frame(0, -1, 0, -1, -1);
    vsync_pulse();
    check_writes("white", 0);
    chk("white_fd_count", fd_seen, 1);
    send_frame(1, -1, 0, -1, -1);
    vsync_pulse();
    check_writes("thresh", 1);
    send_frame(2, -1, 0, -1, -1);
    vsync_pulse();
    check_writes("odd_px", 2);

    // geometry error: 7-pixel line 1
    send_frame(0, 1, 7, -1, -1);
    chk("geo_err_count", bus.err_count, 1);
    chk("geo_locked", bus.locked, 0);
    chk("geo_writes", obs_addr.size(), 4);
    vsync_pulse();
    send_frame(0, -1, 0, -1, -1);
    chk("geo_measure_writes", obs_addr.size(), 0);
    vsync_pulse();
    chk("geo_relock", bus.locked, 1);
    send_frame(0, -1, 0, -1, -1);
    vsync_pulse();
    check_writes("geo_after", 0);

    // async reset in the middle of line 1
    send_frame(0, -1, 0, 1, 3);
    vsync_pulse();
    chk("rst_measuring", bus.locked, 0);
    send_frame(0, -1, 0, -1, -1);
    chk("rst_measure_writes", obs_addr.size(), 0);
    vsync_pulse();
    chk("rst_relock", bus.locked, 1);
    send_frame(1, -1, 0, -1, -1);
    vsync_pulse();
    check_writes("rst_after", 1);

    repeat (8) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("fd_q_empty", fd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
